// File: rtl/uart_tx.sv
// UART transmitter: a small byte FIFO feeding a serializer, 8N1 by default,
// 8E1 when the macro UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       tx_o,
    output logic [2:0] dbg_state_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BIT_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_n;
    logic [15:0]      bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             tx_n, busy_n;
    logic             push, pop;
`ifdef UART_TX_PARITY_EN
    logic             par, par_n;
`endif

    // Handshake: a byte transfers on a rising edge where tx_valid_i and
    // tx_ready_o are both high; ready depends only on the registered count.
    assign tx_ready_o  = (count < DEPTH_C);
    assign push        = tx_valid_i && tx_ready_o;
    assign dbg_state_o = state;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_n   = START;
                    bit_cnt_n = BIT_RELOAD;
                    shift_n   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                    par_n     = ^mem[rd_ptr];
`endif
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    state_n   = DATA;
                    bit_cnt_n = BIT_RELOAD;
                    bit_idx_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_n = BIT_RELOAD;
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_cnt == '0) begin
                    state_n   = STOP;
                    bit_cnt_n = BIT_RELOAD;
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_cnt == '0) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_n   = START;
                        bit_cnt_n = BIT_RELOAD;
                        shift_n   = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_n     = ^mem[rd_ptr];
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bit_cnt_n = bit_cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + CNT_ONE;
        end else if (!push && pop) begin
            count_n = count - CNT_ONE;
        end
    end

    // Line level and busy are computed from next-state values and registered,
    // so both outputs are glitch-free across frame boundaries.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            IDLE:   tx_n = 1'b1;
            START:  tx_n = 1'b0;
            DATA:   tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_n = par_n;
`endif
            STOP:   tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            count   <= count_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_o    <= tx_n;
            busy_o  <= busy_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data_i;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (BAUD_DIV 4 and 2) checked cycle by cycle
// against an ideal line waveform built from the queued bytes.
module tb_uart_tx;
    localparam int DIV_A = 4;
    localparam int DIV_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN     = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] drv_data;
    logic       drv_valid;
    logic       sel;
    logic       valid_a, ready_a, busy_a, tx_a;
    logic       valid_b, ready_b, busy_b, tx_b;
    logic [2:0] dbg_a, dbg_b;
    logic       tx_s, ready_s, busy_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:0] exp_q[$];
    logic [7:0] src_q[$];
    int         acc_edge[$];
    logic       rdy_log[$];

    always #5 clk = ~clk;

    assign valid_a = drv_valid & ~sel;
    assign valid_b = drv_valid & sel;
    assign tx_s    = sel ? tx_b : tx_a;
    assign ready_s = sel ? ready_b : ready_a;
    assign busy_s  = sel ? busy_b : busy_a;

    uart_tx #(.BAUD_DIV(DIV_A), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .tx_data_i(drv_data), .tx_valid_i(valid_a),
        .tx_ready_o(ready_a), .busy_o(busy_a), .tx_o(tx_a), .dbg_state_o(dbg_a)
    );

    uart_tx #(.BAUD_DIV(DIV_B), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .tx_data_i(drv_data), .tx_valid_i(valid_b),
        .tx_ready_o(ready_b), .busy_o(busy_b), .tx_o(tx_b), .dbg_state_o(dbg_b)
    );

    // Ideal frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic void add_frame(input logic [7:0] b, input int div);
        logic [0:0] bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (PAR_EN) bits.push_back(^b);
        bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int r = 0; r < div; r++) exp_q.push_back(bits[j]);
        end
    endfunction

    // Holds tx_valid high while src_q has bytes; optionally pokes 0xAA while
    // ready is low. Compares the line every cycle once the first frame begins.
    task automatic run_stream(input bit poke, input int limit, output int pokes);
        int   cyc = 0;
        int   k = 0;
        int   first_edge = -1;
        bit   started = 1'b0;
        bit   push_now;
        logic [0:0] e;
        pokes = 0;
        acc_edge.delete();
        rdy_log.delete();
        exp_q.delete();
        foreach (src_q[i]) add_frame(src_q[i], sel ? DIV_B : DIV_A);
        while (exp_q.size() > 0 && cyc < limit) begin
            if (started) begin
                e = exp_q.pop_front();
                n_checks++;
                if (tx_s !== e[0]) begin
                    n_fail++;
                    $display("FAIL stream_tx t=%0t got %b expected %b", $time, tx_s, e[0]);
                end
                n_checks++;
                if (busy_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_busy t=%0t got %b expected 1", $time, busy_s);
                end
            end else begin
                n_checks++;
                if (tx_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pre_start_tx t=%0t got %b expected 1", $time, tx_s);
                end
            end
            if (src_q.size() > 0) begin
                drv_valid = 1'b1;
                drv_data  = src_q[0];
            end else if (poke && ready_s === 1'b0) begin
                drv_valid = 1'b1;
                drv_data  = 8'hAA;
                pokes++;
            end else begin
                drv_valid = 1'b0;
            end
            rdy_log.push_back(ready_s);
            push_now = (src_q.size() > 0) && drv_valid && (ready_s === 1'b1);
            @(posedge clk);
            if (push_now) begin
                void'(src_q.pop_front());
                acc_edge.push_back(k);
                if (first_edge < 0) first_edge = k;
            end
            if (first_edge >= 0 && k == first_edge + 1) started = 1'b1;
            @(negedge clk);
            k++;
            cyc++;
        end
        drv_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_timeout remaining %0d samples, expected 0", exp_q.size());
        end
        n_checks++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end tx=%b busy=%b expected tx=1 busy=0", tx_s, busy_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv_valid = 1'b0;
        drv_data = 8'h00;
        sel = 1'b0;
        #1;
        n_checks++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_a tx/ready/busy=%b expected 110", {tx_a, ready_a, busy_a});
        end
        n_checks++;
        if ({tx_b, ready_b, busy_b} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_b tx/ready/busy=%b expected 110", {tx_b, ready_b, busy_b});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int p;
        sel = 1'b0;
        src_q = '{8'h32};
        run_stream(1'b0, 200, p);
    endtask

    task automatic test_back_to_back();
        int p;
        int pop_edge;
        sel = 1'b0;
        src_q = '{8'h32, 8'h30, 8'h32, 8'h33, 8'h32, 8'h31};
        run_stream(1'b0, 2000, p);
        pop_edge = 1 + FRAME_BITS * DIV_A;
        n_checks++;
        if (acc_edge.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_accepts got %0d expected 6", acc_edge.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (acc_edge[i] != i) begin
                    n_fail++;
                    $display("FAIL b2b_edge%0d got %0d expected %0d", i, acc_edge[i], i);
                end
            end
            n_checks++;
            if (acc_edge[5] != pop_edge + 1) begin
                n_fail++;
                $display("FAIL b2b_sixth_edge got %0d expected %0d", acc_edge[5], pop_edge + 1);
            end
        end
        if (rdy_log.size() > pop_edge) begin
            n_checks++;
            if (rdy_log[5] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready_full got %b expected 0", rdy_log[5]);
            end
            n_checks++;
            if (rdy_log[pop_edge] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ready_at_pop got %b expected 0", rdy_log[pop_edge]);
            end
        end
    endtask

    task automatic test_full_drop();
        int p;
        sel = 1'b0;
        src_q.delete();
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom_range(0, 255)));
        run_stream(1'b1, 2000, p);
        n_checks++;
        if (p == 0) begin
            n_fail++;
            $display("FAIL full_poke_count got 0 expected nonzero");
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        @(negedge clk);
        drv_data = 8'h55;
        drv_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        drv_data = 8'h5A;
        @(posedge clk); @(negedge clk);
        drv_data = 8'hC3;
        @(posedge clk); @(negedge clk);
        drv_valid = 1'b0;
        repeat (16) @(negedge clk);
        n_checks++;
        if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_bit3 tx=%b busy=%b expected tx=0 busy=1", tx_a, busy_a);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_a, ready_a, busy_a} !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_reset tx/ready/busy=%b expected 110", {tx_a, ready_a, busy_a});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME_BITS * DIV_A; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_a, ready_a, busy_a} !== 3'b110) begin
                n_fail++;
                $display("FAIL post_reset_quiet t=%0t tx/ready/busy=%b expected 110", $time, {tx_a, ready_a, busy_a});
            end
        end
    endtask

    task automatic test_min_baud();
        int p;
        sel = 1'b1;
        src_q = '{8'h00, 8'hFF};
        run_stream(1'b0, 500, p);
        sel = 1'b0;
    endtask

    task automatic test_random();
        int p;
        int n;
        for (int it = 0; it < 6; it++) begin
            sel = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 7);
            src_q.delete();
            for (int i = 0; i < n; i++) src_q.push_back(8'($urandom_range(0, 255)));
            run_stream(1'($urandom_range(0, 1)), 4000, p);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drop();
        test_reset_mid();
        test_min_baud();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
